// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI slave byte/frame receiver with idle-gap framing; CRC check built only when SPI_FRAME_RX_CRC_EN is defined
module spi_frame_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_CYCLES = 1024,
   parameter int MAX_BYTES   = 64,
   parameter int LEN_W       = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_sclk,
   input  logic             spi_din,
   output logic [7:0]       byte_data,
   output logic             byte_valid,
   output logic             byte_first,
   output logic             frame_end,
   output logic [LEN_W-1:0] frame_len,
   output logic             frame_err,
   output logic             crc_ok
);

   localparam int                IDLE_W    = $clog2(IDLE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [LEN_W-1:0]  MAX_CNT   = LEN_W'(MAX_BYTES);
   localparam logic [LEN_W-1:0]  MIN_CRC   = LEN_W'(3);

   typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_CLOSE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
   logic                   sclk_dly_q, sclk_dly_d;
   logic [6:0]             shreg_q, shreg_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]       byte_cnt_q, byte_cnt_d;
   logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
   logic                   ovf_q, ovf_d;
   logic [7:0]             byte_data_q, byte_data_d;
   logic                   byte_valid_q, byte_valid_d;
   logic                   byte_first_q, byte_first_d;
   logic                   frame_end_q, frame_end_d;
   logic [LEN_W-1:0]       frame_len_q, frame_len_d;
   logic                   frame_err_q, frame_err_d;
   logic                   crc_ok_q, crc_ok_d;

   logic                   rise;
   logic                   din_s;
   logic [7:0]             new_byte;
   logic                   close_err;

   assign rise      = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
   assign din_s     = din_sync_q[SYNC_STAGES-1];
   assign new_byte  = {shreg_q, din_s};
   assign close_err = (bit_cnt_q != 3'd0) | ovf_q;

`ifdef SPI_FRAME_RX_CRC_EN
   logic [15:0] crc_q, crc_d;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      end
      return r;
   endfunction
`endif

   // Next-state: synchronisers, bit shifting, byte emission and the idle-gap frame FSM
   always_comb begin
      state_d      = state_q;
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      din_sync_d   = {din_sync_q[SYNC_STAGES-2:0], spi_din};
      sclk_dly_d   = sclk_sync_q[SYNC_STAGES-1];
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      ovf_d        = ovf_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = 1'b0;
      byte_first_d = 1'b0;
      frame_end_d  = 1'b0;
      frame_len_d  = frame_len_q;
      frame_err_d  = frame_err_q;
      crc_ok_d     = crc_ok_q;
`ifdef SPI_FRAME_RX_CRC_EN
      crc_d        = crc_q;
      if (byte_valid_q) begin
         crc_d = crc16_byte(crc_q, byte_data_q);
      end
`endif

      if (rise) begin
         shreg_d   = new_byte[6:0];
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q < MAX_CNT) begin
               byte_valid_d = 1'b1;
               byte_data_d  = new_byte;
               byte_first_d = (byte_cnt_q == '0);
               byte_cnt_d   = byte_cnt_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            idle_cnt_d = '0;
            if (rise) state_d = ST_RX;
         end
         ST_RX: begin
            if (rise) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
               // Close actions land together with entry to CLOSE, so a rise
               // during the CLOSE cycle already sees cleared counters.
               state_d     = ST_CLOSE;
               idle_cnt_d  = '0;
               frame_end_d = 1'b1;
               frame_len_d = byte_cnt_q;
               frame_err_d = close_err;
`ifdef SPI_FRAME_RX_CRC_EN
               crc_ok_d    = (crc_q == 16'h0000) & ~close_err & (byte_cnt_q >= MIN_CRC);
               crc_d       = 16'hFFFF;
`else
               crc_ok_d    = 1'b1;
`endif
               bit_cnt_d   = 3'd0;
               byte_cnt_d  = '0;
               ovf_d       = 1'b0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         ST_CLOSE: begin
            idle_cnt_d = '0;
            state_d    = rise ? ST_RX : ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
         end
      endcase
   end

   // State and registered outputs; reset drops any partial frame silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sclk_sync_q  <= '0;
         din_sync_q   <= '0;
         sclk_dly_q   <= 1'b0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         idle_cnt_q   <= '0;
         ovf_q        <= 1'b0;
         byte_data_q  <= '0;
         byte_valid_q <= 1'b0;
         byte_first_q <= 1'b0;
         frame_end_q  <= 1'b0;
         frame_len_q  <= '0;
         frame_err_q  <= 1'b0;
         crc_ok_q     <= 1'b0;
`ifdef SPI_FRAME_RX_CRC_EN
         crc_q        <= 16'hFFFF;
`endif
      end else begin
         state_q      <= state_d;
         sclk_sync_q  <= sclk_sync_d;
         din_sync_q   <= din_sync_d;
         sclk_dly_q   <= sclk_dly_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         ovf_q        <= ovf_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         byte_first_q <= byte_first_d;
         frame_end_q  <= frame_end_d;
         frame_len_q  <= frame_len_d;
         frame_err_q  <= frame_err_d;
         crc_ok_q     <= crc_ok_d;
`ifdef SPI_FRAME_RX_CRC_EN
         crc_q        <= crc_d;
`endif
      end
   end

   assign byte_data  = byte_data_q;
   assign byte_valid = byte_valid_q;
   assign byte_first = byte_first_q;
   assign frame_end  = frame_end_q;
   assign frame_len  = frame_len_q;
   assign frame_err  = frame_err_q;
   assign crc_ok     = crc_ok_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed table-driven bench for spi_frame_rx
module tb_spi_frame_rx;

   localparam int IDLE = 1024;
`ifdef SPI_FRAME_RX_CRC_EN
   localparam int MAXB = 16;
`else
   localparam int MAXB = 4;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sclk;
   logic       spi_din;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_first;
   logic       frame_end;
   logic [6:0] frame_len;
   logic       frame_err;
   logic       crc_ok;

   spi_frame_rx #(
      .SYNC_STAGES(2),
      .IDLE_CYCLES(IDLE),
      .MAX_BYTES(MAXB),
      .LEN_W(7)
   ) dut (
      .clk(clk),
      .rst(rst),
      .spi_sclk(spi_sclk),
      .spi_din(spi_din),
      .byte_data(byte_data),
      .byte_valid(byte_valid),
      .byte_first(byte_first),
      .frame_end(frame_end),
      .frame_len(frame_len),
      .frame_err(frame_err),
      .crc_ok(crc_ok)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           nbits;
      logic [159:0] data;
      int           exp_nv;
      int           exp_len;
      int           exp_err;
   } vec_t;

   vec_t       vecs[7];
   int         n_vec;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         fe_cnt = 0;
   int         bv_cyc = 0;
   int         fe_cyc = 0;
   logic [7:0] vq[$];
   bit         fq[$];
   int         lenq[$];
   int         errq[$];
   int         crcq[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Output monitor, sampling on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (byte_valid) begin
         vq.push_back(byte_data);
         fq.push_back(byte_first);
         bv_cyc = cyc;
      end
      if (frame_end) begin
         fe_cnt++;
         fe_cyc = cyc;
         lenq.push_back(int'(frame_len));
         errq.push_back(int'(frame_err));
         crcq.push_back(int'(crc_ok));
         chk("bv_fe_exclusive", int'(byte_valid), 0);
      end
   end

   initial begin
      #(700000 * 10);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic clear_mon();
      vq.delete();
      fq.delete();
      lenq.delete();
      errq.delete();
      crcq.delete();
      fe_cnt = 0;
   endtask

   task automatic send_bit(input logic b);
      spi_sclk = 1'b0;
      spi_din  = b;
      repeat (8) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic send_bits(input logic [159:0] d, input int n);
      for (int i = 0; i < n; i++) send_bit(d[159-i]);
   endtask

   task automatic wait_fe(input int n, input int budget);
      int k;
      k = 0;
      while (fe_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (fe_cnt < n) chk("frame_end_timeout", fe_cnt, n);
      repeat (20) @(negedge clk);
   endtask

   function automatic int exp_crc_ok(input logic [159:0] d, input int nv, input int err, input int len);
`ifdef SPI_FRAME_RX_CRC_EN
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < nv; i++) begin
         c = c ^ {d[159-8*i -: 8], 8'h00};
         for (int j = 0; j < 8; j++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      end
      return (c == 16'h0000 && err == 0 && len >= 3) ? 1 : 0;
`else
      return 1;
`endif
   endfunction

   initial begin
      logic [159:0] d;
      vecs[0] = '{24, {8'hA5, 8'h3C, 8'hFF, 136'd0}, 3, 3, 0};
      vecs[1] = '{12, {12'hABC, 148'd0}, 1, 1, 1};
      vecs[2] = '{8 * (MAXB + 2), 160'h0102030405060708090A0B0C0D0E0F1011121314, MAXB, MAXB, 1};
      vecs[3] = '{8, {8'h5A, 152'd0}, 1, 1, 0};
      vecs[4] = '{5, {5'b10101, 155'd0}, 0, 0, 1};
      n_vec = 5;
`ifdef SPI_FRAME_RX_CRC_EN
      vecs[5] = '{88, {72'h313233343536373839, 8'h29, 8'hB1, 72'd0}, 11, 11, 0};
      vecs[6] = '{88, {72'h303233343536373839, 8'h29, 8'hB1, 72'd0}, 11, 11, 0};
      n_vec = 7;
`endif

      rst = 1'b1;
      spi_sclk = 1'b0;
      spi_din = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_byte_valid", int'(byte_valid), 0);
      chk("rst_byte_first", int'(byte_first), 0);
      chk("rst_byte_data", int'(byte_data), 0);
      chk("rst_frame_end", int'(frame_end), 0);
      chk("rst_frame_len", int'(frame_len), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_crc_ok", int'(crc_ok), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      for (int v = 0; v < n_vec; v++) begin
         clear_mon();
         d = vecs[v].data;
         send_bits(d, vecs[v].nbits);
         wait_fe(1, IDLE + 100);
         chk($sformatf("v%0d_fe_count", v), fe_cnt, 1);
         chk($sformatf("v%0d_nvalid", v), vq.size(), vecs[v].exp_nv);
         for (int i = 0; i < vq.size() && i < vecs[v].exp_nv; i++) begin
            chk($sformatf("v%0d_byte%0d", v, i), int'(vq[i]), int'(d[159-8*i -: 8]));
            chk($sformatf("v%0d_first%0d", v, i), int'(fq[i]), (i == 0) ? 1 : 0);
         end
         if (lenq.size() > 0) begin
            chk($sformatf("v%0d_len", v), lenq[0], vecs[v].exp_len);
            chk($sformatf("v%0d_err", v), errq[0], vecs[v].exp_err);
            chk($sformatf("v%0d_crc_ok", v), crcq[0],
                exp_crc_ok(d, vecs[v].exp_nv, vecs[v].exp_err, vecs[v].exp_len));
         end
         if (v == 0) chk("v0_fe_latency", fe_cyc - bv_cyc, IDLE);
      end

      // rise-to-rise gap of IDLE-1 keeps one frame open
      clear_mon();
      send_bits({8'h11, 152'd0}, 8);
      repeat (IDLE - 1 - 16) @(negedge clk);
      send_bits({8'h22, 152'd0}, 8);
      wait_fe(1, IDLE + 100);
      chk("gap_short_fe_count", fe_cnt, 1);
      chk("gap_short_nvalid", vq.size(), 2);
      if (vq.size() == 2) begin
         chk("gap_short_byte1", int'(vq[1]), 8'h22);
         chk("gap_short_first0", int'(fq[0]), 1);
         chk("gap_short_first1", int'(fq[1]), 0);
      end
      if (lenq.size() > 0) begin
         chk("gap_short_len", lenq[0], 2);
         chk("gap_short_err", errq[0], 0);
      end

      // gap of IDLE+5 splits into two frames
      clear_mon();
      send_bits({8'h11, 152'd0}, 8);
      repeat (IDLE + 5 - 16) @(negedge clk);
      send_bits({8'h22, 152'd0}, 8);
      wait_fe(2, IDLE + 100);
      chk("gap_long_fe_count", fe_cnt, 2);
      if (lenq.size() == 2) begin
         chk("gap_long_len0", lenq[0], 1);
         chk("gap_long_len1", lenq[1], 1);
         chk("gap_long_err1", errq[1], 0);
      end
      chk("gap_long_first_count", int'(fq.size() == 2 && fq[0] && fq[1]), 1);

      // reset after the 5th bit of byte 2 discards the frame
      clear_mon();
      send_bits({8'h33, 5'b10110, 147'd0}, 13);
      spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_mon();
      repeat (IDLE + 50) @(negedge clk);
      chk("rst_mid_no_fe", fe_cnt, 0);
      chk("rst_mid_len_cleared", int'(frame_len), 0);
      send_bits({8'h44, 8'h55, 144'd0}, 16);
      wait_fe(1, IDLE + 100);
      chk("post_rst_fe_count", fe_cnt, 1);
      chk("post_rst_nvalid", vq.size(), 2);
      if (vq.size() == 2) begin
         chk("post_rst_byte0", int'(vq[0]), 8'h44);
         chk("post_rst_byte1", int'(vq[1]), 8'h55);
         chk("post_rst_first0", int'(fq[0]), 1);
      end
      if (lenq.size() > 0) begin
         chk("post_rst_len", lenq[0], 2);
         chk("post_rst_err", errq[0], 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Front-end SPI slave receiver that sits directly upstream of the command depacketiser.
- Oversamples the asynchronous spi_sclk/spi_din pair on clk and deserialises MSB-first bytes.
- Delimits frames by an sclk idle gap, since the board has no chip-select line.
- Delivers a byte stream with first-byte and end-of-frame markers, a frame length and error flags, so the depacketiser no longer touches raw SPI pins.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on spi_sclk and spi_din (min 2).
- IDLE_CYCLES, 1024: clk cycles without an sclk rising edge that close an open frame.
- MAX_BYTES, 64: maximum bytes emitted per frame.
- LEN_W, 7: width of frame_len; must hold MAX_BYTES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- spi_sclk  in  1  SPI clock from host, asynchronous, data valid on rising edge.
- spi_din  in  1  SPI data from host, MSB first.
- byte_data  out  8  received byte; valid when byte_valid=1.
- byte_valid  out  1  one-cycle strobe per emitted byte.
- byte_first  out  1  high with byte_valid on the first byte of a frame.
- frame_end  out  1  one-cycle strobe when a frame closes.
- frame_len  out  LEN_W  bytes emitted in the last closed frame; held until the next frame_end.
- frame_err  out  1  status of the last closed frame (partial byte or overflow); held until the next frame_end.
- crc_ok  out  1  CRC result of the last closed frame; held until the next frame_end (see Optional Feature).

Behaviour:
- Reset value of all outputs is 0. Reset also clears the synchronisers, shift register, bit/byte/idle counters and the overflow flag.
- Reset asserted mid-frame discards the partial frame and emits no frame_end. After release, the next edge starts a new frame.
- Edge detect: sclk passes through SYNC_STAGES flops, plus one delay flop. rise = sync & ~delayed. din is sampled from its own synchroniser in the same rise cycle. Pin-to-sample latency is SYNC_STAGES+1 clk.
- Shift: on rise, shreg <= {shreg[6:0], din_s} and bit_cnt (3 bit) increments, wrapping from 7 to 0.
- On the rise that completes bit 8, the byte registers. The cycle after, byte_valid=1 for exactly one cycle with byte_data = completed byte, provided byte_cnt < MAX_BYTES. byte_first=1 iff byte_cnt was 0. byte_cnt then increments.
- Overflow: a completed byte with byte_cnt = MAX_BYTES is dropped (no byte_valid) and sets the sticky ovf flag. byte_cnt saturates at MAX_BYTES.
- State machine:
  - IDLE: no bits or bytes pending, idle counter held at 0. A rise moves to RX.
  - RX: idle_cnt clears on every rise and increments by 1 on every other cycle.
  - When idle_cnt reaches IDLE_CYCLES-1 with no rise that cycle, move to CLOSE.
  - CLOSE (one cycle):
    - frame_end=1 for one cycle.
    - frame_len <= byte_cnt.
    - frame_err <= (bit_cnt != 0) | ovf.
    - crc_ok updated.
    - bit_cnt, byte_cnt, ovf and CRC state cleared.
    - Return to IDLE.
- Simultaneous events:
  - A rise in the cycle idle_cnt hits its threshold wins: the frame stays open.
  - A rise arriving during CLOSE is captured as bit 1 of the next frame. The CLOSE cycle has already cleared the counters, so this bit is not lost.
- A frame of only partial bits (0 bytes) still closes with frame_end=1, frame_len=0, frame_err=1.
- byte_valid and frame_end are never high in the same cycle.
- No backpressure: the consumer must accept byte_valid every cycle.
- A byte needs at least 8 sclk periods, and each period must be ≥ 4 clk. Faster sclk is out of spec; behaviour is undefined but must not lock up.

Optional Feature:
- Macro: SPI_FRAME_RX_CRC_EN.
- When defined:
  - A CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no xorout) runs over every emitted byte, processing one byte per byte_valid cycle.
  - The host appends the CRC MSB-first, so a good frame leaves residue 0x0000.
  - At CLOSE: crc_ok <= (residue == 0) & ~frame_err & (byte_cnt >= 3).
- When undefined: no CRC logic is built, and crc_ok is driven 1 at each CLOSE and 0 from reset.

Test Plan:
- Reset held 20 clk, then 3 bytes 0xA5,0x3C,0xFF at sclk period 16 clk, then idle 1100 clk -> 3 byte_valid with data A5/3C/FF, byte_first only on A5; one frame_end IDLE_CYCLES clk after the last rise; frame_len=3, frame_err=0.
- 12 sclk bits (1.5 bytes), then idle -> one byte_valid; frame_end with frame_len=1, frame_err=1.
- MAX_BYTES=4, send 6 bytes -> exactly 4 byte_valid; frame_len=4, frame_err=1; the next clean 1-byte frame gives frame_err=0.
- Gap of exactly IDLE_CYCLES-1 clk between two bytes -> single frame, frame_len=2; a gap of IDLE_CYCLES+5 -> two frames, each frame_len=1.
- rst pulsed after the 5th bit of byte 2 -> no frame_end; a following 2-byte frame reports frame_len=2 and byte_first on its first byte.
- With SPI_FRAME_RX_CRC_EN: send "123456789" plus CRC 0x29,0xB1 -> crc_ok=1, frame_len=11; flip one data bit -> crc_ok=0.
